// File: rtl/cppf_tx_pkg.sv
// rtl/cppf_tx_pkg.sv - shared types and constants for the CPPF transmit slot scheduler
package cppf_tx_pkg;

  localparam int WORDS_PER_BX  = 6;
  localparam int BX_PER_ORBIT  = 3564;
  localparam int BX_TRAILER    = 3555;
  localparam int BX_RESERVED_F = 3556;
  localparam int BX_RESERVED_L = 3559;
  localparam int MAX_GAP       = 1;
  localparam int BXN_W         = 12;

  localparam logic [2:0] WORD_SEL_PAD = 3'd7;
  localparam logic [2:0] WORD_LAST    = 3'(WORDS_PER_BX - 1);

  typedef enum logic [1:0] {
    SLOT_PAD     = 2'd0,
    SLOT_PAYLOAD = 2'd1,
    SLOT_TRAILER = 2'd2,
    SLOT_COMMA   = 2'd3
  } slot_t;

  typedef enum logic [1:0] {
    ST_SYNC_WAIT = 2'd0,
    ST_SEND      = 2'd1,
    ST_GAP       = 2'd2
  } state_t;

  // Slot class of a BX, before the payload handshake can demote it to PAD
  function automatic slot_t classify_slot(input logic [BXN_W-1:0] bxn);
    if (bxn == BXN_W'(BX_TRAILER)) begin
      return SLOT_TRAILER;
    end
    if (bxn >= BXN_W'(BX_RESERVED_F) && bxn <= BXN_W'(BX_RESERVED_L)) begin
      return SLOT_COMMA;
    end
    return SLOT_PAYLOAD;
  endfunction

endpackage

// File: rtl/cppf_bx_counter.sv
// rtl/cppf_bx_counter.sv - LHC bunch-crossing counter with orbit wrap and bc0 alignment check
module cppf_bx_counter
  import cppf_tx_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             bc0,
  input  logic             check_en,
  output logic [BXN_W-1:0] bxn,
  output logic [BXN_W-1:0] bxn_next,
  output logic             mismatch
);

  logic [BXN_W-1:0] bxn_q;
  logic [BXN_W-1:0] bxn_d;
  logic [BXN_W-1:0] bxn_inc;

  // Next bxn: bc0 always forces zero; a mismatch means the free-running count disagreed
  always_comb begin
    bxn_inc  = (bxn_q == BXN_W'(BX_PER_ORBIT - 1)) ? '0 : bxn_q + 1'b1;
    bxn_d    = bxn_q;
    mismatch = 1'b0;
    if (advance) begin
      if (bc0) begin
        bxn_d    = '0;
        mismatch = check_en && (bxn_inc != '0);
      end else begin
        bxn_d = bxn_inc;
      end
    end
  end

  // bxn register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bxn_q <= '0;
    end else begin
      bxn_q <= bxn_d;
    end
  end

  assign bxn      = bxn_q;
  assign bxn_next = bxn_d;

endmodule

// File: rtl/cppf_tx_scheduler.sv
// rtl/cppf_tx_scheduler.sv - per-BX word sequencer, payload handshake and link error tracking
module cppf_tx_scheduler
  import cppf_tx_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk_250,
  input  logic                 rst_n,
  input  logic                 bx_strobe,
  input  logic                 bc0,
  input  logic                 payload_valid,
  output logic                 payload_ready,
  output logic                 word_valid,
  output logic [2:0]           word_sel,
  output logic [1:0]           slot_type,
  output logic                 crc_clear,
  output logic                 crc_insert,
  output logic [11:0]          bxn,
  output logic [2:0]           link_err,
  output logic [ERR_CNT_W-1:0] underflow_cnt,
  input  logic                 err_clear
);

  state_t                 state_q, state_d;
  logic [2:0]             word_idx_q, word_idx_d;
  logic [1:0]             gap_cnt_q, gap_cnt_d;
  slot_t                  slot_q, slot_d;
  logic                   payload_ready_q, payload_ready_d;
  logic                   crc_clear_q, crc_clear_d;
  logic                   crc_insert_q, crc_insert_d;
  logic [2:0]             link_err_q, link_err_d;
  logic [ERR_CNT_W-1:0]   ucnt_q, ucnt_d;

  logic                   accept;
  logic                   set_overrun;
  logic                   set_gap;
  logic                   set_underflow;
  logic                   bc0_mismatch;
  logic [BXN_W-1:0]       bxn_cur;
  logic [BXN_W-1:0]       bxn_next;

  // Until aligned, only a bc0 strobe may start the sequence
  assign accept = bx_strobe && ((state_q != ST_SYNC_WAIT) || bc0);

  cppf_bx_counter u_bx_counter (
    .clk      (clk_250),
    .rst_n    (rst_n),
    .advance  (accept),
    .bc0      (bc0),
    .check_en (state_q != ST_SYNC_WAIT),
    .bxn      (bxn_cur),
    .bxn_next (bxn_next),
    .mismatch (bc0_mismatch)
  );

  // Sequencer: next state, word index, slot class and per-word strobes
  always_comb begin
    state_d         = state_q;
    word_idx_d      = word_idx_q;
    gap_cnt_d       = gap_cnt_q;
    slot_d          = slot_q;
    payload_ready_d = 1'b0;
    crc_clear_d     = 1'b0;
    crc_insert_d    = 1'b0;
    set_overrun     = 1'b0;
    set_gap         = 1'b0;
    set_underflow   = 1'b0;

    if (accept) begin
      state_d     = ST_SEND;
      word_idx_d  = '0;
      gap_cnt_d   = '0;
      crc_clear_d = (bxn_next == '0);
      slot_d      = classify_slot(bxn_next);
      if (slot_d == SLOT_PAYLOAD) begin
        if (payload_valid) begin
          payload_ready_d = 1'b1;
        end else begin
          slot_d        = SLOT_PAD;
          set_underflow = 1'b1;
        end
      end
      set_overrun = (state_q == ST_SEND) && (word_idx_q != WORD_LAST);
    end else begin
      unique case (state_q)
        ST_SEND: begin
          if (word_idx_q == WORD_LAST) begin
            state_d   = ST_GAP;
            gap_cnt_d = 2'd1;
          end else begin
            word_idx_d   = word_idx_q + 3'd1;
            crc_insert_d = (word_idx_q == 3'd0) && (slot_q == SLOT_TRAILER);
          end
        end
        ST_GAP: begin
          set_gap   = (gap_cnt_q >= 2'(MAX_GAP));
          gap_cnt_d = (gap_cnt_q == 2'd3) ? gap_cnt_q : gap_cnt_q + 2'd1;
        end
        default: begin
          state_d = ST_SYNC_WAIT;
        end
      endcase
    end
  end

  // Sticky errors and saturating underflow count; a new event beats err_clear
  always_comb begin
    link_err_d = err_clear ? 3'b000 : link_err_q;
    link_err_d = link_err_d | {bc0_mismatch, set_gap, set_overrun};
    ucnt_d     = err_clear ? '0 : ucnt_q;
    if (set_underflow) begin
      ucnt_d = (ucnt_q == {ERR_CNT_W{1'b1}}) ? ucnt_q : ucnt_q + 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clk_250 or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_SYNC_WAIT;
      word_idx_q      <= '0;
      gap_cnt_q       <= '0;
      slot_q          <= SLOT_PAD;
      payload_ready_q <= 1'b0;
      crc_clear_q     <= 1'b0;
      crc_insert_q    <= 1'b0;
      link_err_q      <= '0;
      ucnt_q          <= '0;
    end else begin
      state_q         <= state_d;
      word_idx_q      <= word_idx_d;
      gap_cnt_q       <= gap_cnt_d;
      slot_q          <= slot_d;
      payload_ready_q <= payload_ready_d;
      crc_clear_q     <= crc_clear_d;
      crc_insert_q    <= crc_insert_d;
      link_err_q      <= link_err_d;
      ucnt_q          <= ucnt_d;
    end
  end

  assign word_valid    = (state_q == ST_SEND);
  assign word_sel      = (state_q == ST_SEND) ? word_idx_q : WORD_SEL_PAD;
  assign slot_type     = (state_q == ST_SEND) ? slot_q : SLOT_PAD;
  assign payload_ready = payload_ready_q;
  assign crc_clear     = crc_clear_q;
  assign crc_insert    = crc_insert_q;
  assign bxn           = bxn_cur;
  assign link_err      = link_err_q;
  assign underflow_cnt = ucnt_q;

endmodule

// File: tb/tb_cppf_tx_scheduler.sv
// tb/tb_cppf_tx_scheduler.sv - directed self-checking bench for cppf_tx_scheduler
module tb_cppf_tx_scheduler;

  // Narrow counter so saturation is reachable in a short run
  localparam int ERR_CNT_W = 4;

  logic                 clk_250;
  logic                 rst_n;
  logic                 bx_strobe;
  logic                 bc0;
  logic                 payload_valid;
  logic                 payload_ready;
  logic                 word_valid;
  logic [2:0]           word_sel;
  logic [1:0]           slot_type;
  logic                 crc_clear;
  logic                 crc_insert;
  logic [11:0]          bxn;
  logic [2:0]           link_err;
  logic [ERR_CNT_W-1:0] underflow_cnt;
  logic                 err_clear;

  int n_checks = 0;
  int n_pass   = 0;

  cppf_tx_scheduler #(.ERR_CNT_W(ERR_CNT_W)) dut (
    .clk_250       (clk_250),
    .rst_n         (rst_n),
    .bx_strobe     (bx_strobe),
    .bc0           (bc0),
    .payload_valid (payload_valid),
    .payload_ready (payload_ready),
    .word_valid    (word_valid),
    .word_sel      (word_sel),
    .slot_type     (slot_type),
    .crc_clear     (crc_clear),
    .crc_insert    (crc_insert),
    .bxn           (bxn),
    .link_err      (link_err),
    .underflow_cnt (underflow_cnt),
    .err_clear     (err_clear)
  );

  initial clk_250 = 1'b0;
  always #2 clk_250 = ~clk_250;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk_250);
    #1;
  endtask

  task automatic do_strobe(input logic with_bc0);
    bx_strobe = 1'b1;
    bc0       = with_bc0;
    tick();
    bx_strobe = 1'b0;
    bc0       = 1'b0;
  endtask

  task automatic run_bx();
    do_strobe(1'b0);
    repeat (5) tick();
  endtask

  logic seen;

  initial begin
    rst_n         = 1'b0;
    bx_strobe     = 1'b0;
    bc0           = 1'b0;
    payload_valid = 1'b0;
    err_clear     = 1'b0;
    repeat (2) tick();

    chk("rst_word_valid", 32'(word_valid), 32'd0);
    chk("rst_word_sel", 32'(word_sel), 32'd7);
    chk("rst_slot", 32'(slot_type), 32'd0);
    chk("rst_bxn", 32'(bxn), 32'd0);
    chk("rst_link_err", 32'(link_err), 32'd0);
    chk("rst_ucnt", 32'(underflow_cnt), 32'd0);
    chk("rst_ready", 32'(payload_ready), 32'd0);

    rst_n = 1'b1;
    tick();

    // Unaligned strobes at 6/7 spacing must not start the sequence
    payload_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_strobe(1'b0);
      seen |= word_valid;
      repeat (5 + (i % 2)) begin
        tick();
        seen |= word_valid;
      end
    end
    chk("sync_ignore", 32'(seen), 32'd0);

    do_strobe(1'b1);
    chk("sync_valid", 32'(word_valid), 32'd1);
    chk("sync_sel0", 32'(word_sel), 32'd0);
    chk("sync_bxn", 32'(bxn), 32'd0);
    chk("sync_crc_clear", 32'(crc_clear), 32'd1);
    chk("sync_slot", 32'(slot_type), 32'd1);
    chk("sync_ready", 32'(payload_ready), 32'd1);
    tick();
    chk("w1_sel", 32'(word_sel), 32'd1);
    chk("w1_crc_clear", 32'(crc_clear), 32'd0);
    chk("w1_ready", 32'(payload_ready), 32'd0);
    repeat (4) tick();
    chk("w5_sel", 32'(word_sel), 32'd5);

    // Run up to the trailer
    for (int b = 1; b < 3555; b++) run_bx();
    chk("pre_trailer_bxn", 32'(bxn), 32'd3554);
    chk("pre_trailer_err", 32'(link_err), 32'd0);
    do_strobe(1'b0);
    chk("trl_bxn", 32'(bxn), 32'd3555);
    chk("trl_slot", 32'(slot_type), 32'd2);
    chk("trl_ready", 32'(payload_ready), 32'd0);
    chk("trl_ins_w0", 32'(crc_insert), 32'd0);
    tick();
    chk("trl_w1_sel", 32'(word_sel), 32'd1);
    chk("trl_ins_w1", 32'(crc_insert), 32'd1);
    tick();
    chk("trl_ins_w2", 32'(crc_insert), 32'd0);
    repeat (3) tick();

    seen = 1'b0;
    for (int b = 3556; b <= 3559; b++) begin
      do_strobe(1'b0);
      seen |= payload_ready;
      chk("comma_slot", 32'(slot_type), 32'd3);
      repeat (5) tick();
    end
    chk("comma_no_ready", 32'(seen), 32'd0);

    do_strobe(1'b0);
    chk("post_bxn", 32'(bxn), 32'd3560);
    chk("post_slot", 32'(slot_type), 32'd1);
    chk("post_ready", 32'(payload_ready), 32'd1);
    repeat (5) tick();
    for (int b = 3561; b <= 3563; b++) run_bx();

    // bc0 exactly at the natural wrap: no mismatch
    do_strobe(1'b1);
    chk("wrap_bxn", 32'(bxn), 32'd0);
    chk("wrap_crc_clear", 32'(crc_clear), 32'd1);
    chk("wrap_err", 32'(link_err), 32'd0);
    repeat (5) tick();

    // Payload underflow
    for (int b = 1; b <= 9; b++) run_bx();
    payload_valid = 1'b0;
    do_strobe(1'b0);
    chk("uf_bxn", 32'(bxn), 32'd10);
    chk("uf_slot", 32'(slot_type), 32'd0);
    chk("uf_valid", 32'(word_valid), 32'd1);
    chk("uf_ready", 32'(payload_ready), 32'd0);
    chk("uf_cnt1", 32'(underflow_cnt), 32'd1);
    repeat (3) tick();
    chk("uf_slot_w3", 32'(slot_type), 32'd0);
    chk("uf_valid_w3", 32'(word_valid), 32'd1);
    repeat (2) tick();
    for (int i = 0; i < 14; i++) run_bx();
    chk("uf_cnt_max", 32'(underflow_cnt), 32'd15);
    run_bx();
    chk("uf_cnt_sat", 32'(underflow_cnt), 32'd15);
    payload_valid = 1'b1;

    // One pad cycle is legal spacing
    tick();
    chk("gap1_valid", 32'(word_valid), 32'd0);
    chk("gap1_sel", 32'(word_sel), 32'd7);
    do_strobe(1'b0);
    chk("gap1_bxn", 32'(bxn), 32'd26);
    chk("gap1_err", 32'(link_err), 32'd0);
    repeat (3) tick();

    // Overrun at word 3
    do_strobe(1'b0);
    chk("ovr_err", 32'(link_err), 32'd1);
    chk("ovr_sel", 32'(word_sel), 32'd0);
    chk("ovr_bxn", 32'(bxn), 32'd27);
    repeat (5) tick();

    // Strobe withheld three cycles
    repeat (3) tick();
    chk("gap_to_err", 32'(link_err), 32'd3);
    chk("gap_to_valid", 32'(word_valid), 32'd0);
    do_strobe(1'b0);
    chk("gap_to_bxn", 32'(bxn), 32'd28);
    repeat (5) tick();

    // Misplaced bc0
    for (int b = 29; b <= 99; b++) run_bx();
    chk("pre_bc0_bxn", 32'(bxn), 32'd99);
    do_strobe(1'b1);
    chk("bc0_bxn", 32'(bxn), 32'd0);
    chk("bc0_err", 32'(link_err), 32'd7);

    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("clr_err", 32'(link_err), 32'd0);
    chk("clr_ucnt", 32'(underflow_cnt), 32'd0);
    tick();
    chk("pre_rst_sel", 32'(word_sel), 32'd2);

    // Asynchronous reset mid-BX
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(word_valid), 32'd0);
    chk("arst_sel", 32'(word_sel), 32'd7);
    chk("arst_bxn", 32'(bxn), 32'd0);
    chk("arst_slot", 32'(slot_type), 32'd0);
    tick();
    rst_n = 1'b1;
    do_strobe(1'b0);
    chk("resync_ignore", 32'(word_valid), 32'd0);
    repeat (5) tick();
    do_strobe(1'b1);
    chk("resync_valid", 32'(word_valid), 32'd1);
    chk("resync_bxn", 32'(bxn), 32'd0);
    chk("resync_sel", 32'(word_sel), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
